// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub: valid/ready in, valid/ready out.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Define CLA_PIPE_SAT_EN to saturate the signed result on overflow instead of wrapping.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / GROUP;

    typedef struct packed {
        logic             valid;
        logic             carry;   // carry into the next group to be computed
        logic             ovf;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;       // already inverted for subtraction
        logic [WIDTH-1:0] sum;     // bits of completed groups are final
    } stage_t;

    stage_t pipe_q [STAGES];
    stage_t pipe_d [STAGES];
    stage_t entry;
    logic   adv;

    // Returns {group carry-out, group sum}; every carry is a flat lookahead term.
    function automatic logic [GROUP:0] cla_group(
        input logic [GROUP-1:0] ga,
        input logic [GROUP-1:0] gb,
        input logic             c0
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             pp;
        p    = ga | gb;
        g    = ga & gb;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < GROUP; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & c0);
        end
        return {c[GROUP], ga ^ gb ^ c[GROUP-1:0]};
    endfunction

    function automatic stage_t step(input stage_t s, input int k);
        stage_t         r;
        logic [GROUP:0] grp;
        logic           c_msb;
        r       = s;
        grp     = cla_group(s.a[k*GROUP +: GROUP], s.b[k*GROUP +: GROUP], s.carry);
        r.sum[k*GROUP +: GROUP] = grp[GROUP-1:0];
        r.carry = grp[GROUP];
        r.ovf   = 1'b0;
        c_msb   = 1'b0;
        if (k == STAGES - 1) begin
            c_msb = s.a[WIDTH-1] ^ s.b[WIDTH-1] ^ grp[GROUP-1];
            r.ovf = c_msb ^ grp[GROUP];
`ifdef CLA_PIPE_SAT_EN
            // A wrapped negative MSB means the true result was positive.
            if (r.ovf) begin
                r.sum = grp[GROUP-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
            end
`endif
        end
        return r;
    endfunction

    // NOTE: every variable assigned here gets a value on every pass, so no latch is inferred.
    always_comb begin
        entry       = '0;
        entry.valid = bus.in_valid;
        entry.carry = bus.sub | bus.cin;
        entry.a     = bus.a;
        entry.b     = bus.sub ? ~bus.b : bus.b;
        pipe_d[0]   = step(entry, 0);
        for (int k = 1; k < STAGES; k++) begin
            pipe_d[k] = step(pipe_q[k-1], k);
        end
    end

    // NOTE: nonblocking assignments let each stage capture its predecessor's pre-edge value.
    // NOTE: data fields are reset too, since sum must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    // The whole pipe moves in lockstep; a stalled result freezes every stage behind it.
    assign adv           = !pipe_q[STAGES-1].valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = pipe_q[STAGES-1].valid;
    assign bus.sum       = pipe_q[STAGES-1].sum;
    assign bus.cout      = pipe_q[STAGES-1].carry;
    assign bus.ovf       = pipe_q[STAGES-1].ovf;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: a 16/4 four-stage instance and an 8/8 single-stage instance.
module tb_cla_pipe_addsub;
    localparam int W0 = 16;
    localparam int G0 = 4;
    localparam int S0 = W0 / G0;
    localparam int W1 = 8;
    localparam int G1 = 8;
    localparam int S1 = W1 / G1;

`ifdef CLA_PIPE_SAT_EN
    localparam logic [15:0] SUB_OVF = 16'h8000;
    localparam logic [15:0] ADD_OVF = 16'h7FFF;
    localparam logic [15:0] ADD8_OVF = 16'h0080;
`else
    localparam logic [15:0] SUB_OVF = 16'h7FFF;
    localparam logic [15:0] ADD_OVF = 16'h8000;
    localparam logic [15:0] ADD8_OVF = 16'h0001;
`endif

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;      // cycle count seen just before the accepting edge
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   pops0 = 0;
    int   pops1 = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    cla_pipe_addsub_if #(.WIDTH(W0)) bus0 ();
    cla_pipe_addsub_if #(.WIDTH(W1)) bus1 ();

    cla_pipe_addsub #(.WIDTH(W0), .GROUP(G0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cla_pipe_addsub #(.WIDTH(W1), .GROUP(G1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.sum = sum; e.cout = cout; e.ovf = ovf; e.acc = 0; e.chk_lat = 0;
        return e;
    endfunction

    // Reference arithmetic on a w-bit slice of wide integers.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        logic [16:0] mask;
        logic [16:0] bx;
        logic [16:0] full;
        exp_t        e;
        mask = (17'd1 << w) - 17'd1;
        bx   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = ({1'b0, a} & mask) + bx + {16'd0, (sub | cin)};
        e    = mk(full[15:0] & mask[15:0], full[w], 1'b0);
        e.ovf = (a[w-1] == bx[w-1]) && (full[w-1] != a[w-1]);
`ifdef CLA_PIPE_SAT_EN
        if (e.ovf) e.sum = a[w-1] ? 16'(17'd1 << (w - 1)) : 16'((17'd1 << (w - 1)) - 17'd1);
`endif
        return e;
    endfunction

    task automatic drive(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin);
        if (which == 0) begin
            bus0.in_valid = 1'b1; bus0.a = a; bus0.b = b; bus0.sub = sub; bus0.cin = cin;
        end else begin
            bus1.in_valid = 1'b1; bus1.a = a[7:0]; bus1.b = b[7:0]; bus1.sub = sub; bus1.cin = cin;
        end
    endtask

    task automatic idle(input int which);
        if (which == 0) bus0.in_valid = 1'b0;
        else            bus1.in_valid = 1'b0;
    endtask

    // Hold the operands until accepted, then queue the expected result.
    task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin, input exp_t e, input bit chk_lat);
        bit ok = 1'b0;
        drive(which, a, b, sub, cin);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((which == 0) ? bus0.in_ready : bus1.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        e.acc     = cyc;
        e.chk_lat = chk_lat;
        @(posedge clk); #1;
        if (!ok) check("accept_timeout", 32'(ok), 1);
        else if (which == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 40; i++) begin
            if (((which == 0) ? sb0.size() : sb1.size()) == 0) begin
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
        end
        check("drain_timeout", 32'((which == 0) ? sb0.size() : sb1.size()), 0);
    endtask

    // Output monitor: every completed output handshake is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
            pops0++;
            if (sb0.size() == 0) begin
                check("dut0_spurious_valid", 32'(bus0.out_valid), 0);
            end else begin
                e = sb0.pop_front();
                check("dut0_sum", 32'(bus0.sum), 32'(e.sum));
                check("dut0_cout", 32'(bus0.cout), 32'(e.cout));
                check("dut0_ovf", 32'(bus0.ovf), 32'(e.ovf));
                if (e.chk_lat) check("dut0_latency", 32'(cyc - e.acc), S0);
            end
        end
        if (bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
            pops1++;
            if (sb1.size() == 0) begin
                check("dut1_spurious_valid", 32'(bus1.out_valid), 0);
            end else begin
                e = sb1.pop_front();
                check("dut1_sum", 32'(bus1.sum), 32'(e.sum));
                check("dut1_cout", 32'(bus1.cout), 32'(e.cout));
                check("dut1_ovf", 32'(bus1.ovf), 32'(e.ovf));
                if (e.chk_lat) check("dut1_latency", 32'(cyc - e.acc), S1);
            end
        end
    end

    initial begin
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        os [8];
        logic        oc [8];
        int          base;
        int          seen;

        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.sub = 1'b0; bus0.cin = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.cin = 1'b0;
        bus1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(bus0.out_valid), 0);
        check("rst_sum", 32'(bus0.sum), 0);
        check("rst_cout", 32'(bus0.cout), 0);
        check("rst_ovf", 32'(bus0.ovf), 0);
        check("rst_in_ready", 32'(bus0.in_ready), 1);
        check("rst1_out_valid", 32'(bus1.out_valid), 0);
        check("rst1_in_ready", 32'(bus1.in_ready), 1);
        @(posedge clk); #1;

        // Carry ripples through every group register.
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1'b1);
        idle(0);
        drain(0);

        // Subtraction (cin ignored), signed overflow both ways, add with carry-in.
        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b0, mk(16'hFFFE, 1'b0, 1'b0), 1'b1);
        issue(0, 16'h8000, 16'h0001, 1'b1, 1'b1, mk(SUB_OVF, 1'b1, 1'b1), 1'b1);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(ADD_OVF, 1'b0, 1'b1), 1'b1);
        issue(0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, mk(16'h2234, 1'b0, 1'b0), 1'b1);
        idle(0);
        drain(0);

        // Back-to-back: each result exactly S0 cycles after its accept means one per cycle.
        base = pops0;
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom);
            os[i] = 1'($urandom); oc[i] = 1'($urandom);
            issue(0, oa[i], ob[i], os[i], oc[i], model(W0, oa[i], ob[i], os[i], oc[i]), 1'b1);
        end
        idle(0);
        drain(0);
        check("b2b_count", 32'(pops0 - base), 8);

        // Mid-stream back-pressure for three cycles with the next operands held.
        base = pops0;
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom); ob[i] = 16'($urandom);
            os[i] = 1'($urandom); oc[i] = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                drive(0, oa[i], ob[i], os[i], oc[i]);
                bus0.out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(bus0.in_ready), 0);
                    check("stall_out_valid", 32'(bus0.out_valid), 1);
                    check("stall_sum", 32'(bus0.sum), 32'(sb0[0].sum));
                    check("stall_flags", {30'd0, bus0.cout, bus0.ovf}, {30'd0, sb0[0].cout, sb0[0].ovf});
                end
                @(posedge clk); #1;
                bus0.out_ready = 1'b1;
            end
            issue(0, oa[i], ob[i], os[i], oc[i], model(W0, oa[i], ob[i], os[i], oc[i]), 1'b0);
        end
        idle(0);
        drain(0);
        check("stall_count", 32'(pops0 - base), 8);

        // Reset with three operations in flight: none of them may surface.
        for (int i = 0; i < 3; i++) begin
            issue(0, 16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0), 1'b0);
        end
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb0.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(bus0.out_valid), 0);
        check("midrst_sum", 32'(bus0.sum), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus0.out_valid !== 1'b0) seen++;
        end
        check("midrst_no_stale", 32'(seen), 0);
        @(posedge clk); #1;
        issue(0, 16'h4000, 16'h4000, 1'b0, 1'b0, mk(ADD_OVF, 1'b0, 1'b1), 1'b1);
        idle(0);
        drain(0);

        // Single-stage instance: one-cycle latency and 8-bit overflow.
        issue(1, 16'h0080, 16'h0080, 1'b0, 1'b1, mk(ADD8_OVF, 1'b1, 1'b1), 1'b1);
        issue(1, 16'h0010, 16'h0020, 1'b1, 1'b0, mk(16'h00F0, 1'b0, 1'b0), 1'b1);
        for (int i = 0; i < 4; i++) begin
            oa[i] = 16'($urandom_range(0, 255)); ob[i] = 16'($urandom_range(0, 255));
            os[i] = 1'($urandom); oc[i] = 1'($urandom);
            issue(1, oa[i], ob[i], os[i], oc[i], model(W1, oa[i], ob[i], os[i], oc[i]), 1'b1);
        end
        idle(1);
        drain(1);
        check("dut1_count", 32'(pops1), 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
